// File: rtl/mem_pkg.sv
// Shared encodings for the load/store sequencer: access sizes, FSM states, alignment rule.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package mem_pkg;

    // in_size encoding; the access width in bytes is 1 << size
    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_D = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // An access is misaligned when the address is not a multiple of its width.
    // Only the low three address bits can matter for widths up to 8 bytes.
    function automatic logic misalign(input logic [2:0] addr_lo, input logic [1:0] size);
        logic bad;
        case (size)
            SIZE_B:  bad = 1'b0;
            SIZE_H:  bad = addr_lo[0];
            SIZE_W:  bad = |addr_lo[1:0];
            default: bad = |addr_lo[2:0];
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_extend.sv
// Extends the low 1/2/4/8 bytes of a memory word to 64 bits and exports the field byte mask.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   size        access size (mem_pkg SIZE_*)
//   is_unsigned zero-extend instead of sign-extend (no effect for doubleword)
//   raw         memory word, accessed field right-justified
//   ext         extended load data
//   byte_mask   ones over the accessed field; the store merge uses it to splice store bytes
module lsu_extend
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [63:0] raw,
    output logic [63:0] ext,
    output logic [63:0] byte_mask
);

    logic sign;

    always_comb begin
        byte_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        sign      = 1'b0;
        case (size)
            SIZE_B: begin
                byte_mask = 64'h0000_0000_0000_00FF;
                sign      = raw[7];
            end
            SIZE_H: begin
                byte_mask = 64'h0000_0000_0000_FFFF;
                sign      = raw[15];
            end
            SIZE_W: begin
                byte_mask = 64'h0000_0000_FFFF_FFFF;
                sign      = raw[31];
            end
            default: begin
                byte_mask = 64'hFFFF_FFFF_FFFF_FFFF;
                sign      = 1'b0;
            end
        endcase
        // Bits outside the field take the field MSB when signed, zero otherwise.
        ext = (raw & byte_mask) | ({64{sign & ~is_unsigned}} & ~byte_mask);
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer between the MEM stage and a 64-bit byte-addressed data memory.
// Latency: load/SD 2 cycles, SB/SH/SW 3 cycles (read-modify-write), misaligned 1 cycle.
// Backpressure: out_ready only in IDLE; requests seen while busy are dropped, not queued.
//
// Ports:
//   in_clk, in_rst        clock, synchronous active-high reset
//   in_req/out_ready      request handshake; in_we, in_size, in_unsigned, in_addr, in_wdata qualify it
//   out_valid/out_err     one-cycle completion pulse, misalign flag; out_rdata is extended load data
//   out_mem_addr/_data    registered memory address and write data
//   out_mem_wr_en         registered write strobe, high for exactly the WR cycle
//   in_mem_data           memory read data, combinational from out_mem_addr
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64
) (
    input  logic                  in_clk,
    input  logic                  in_rst,
    input  logic                  in_req,
    input  logic                  in_we,
    input  logic [1:0]            in_size,
    input  logic                  in_unsigned,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0] in_wdata,
    output logic                  out_ready,
    output logic                  out_valid,
    output logic                  out_err,
    output logic [DATA_WIDTH-1:0] out_rdata,
    output logic [ADDR_WIDTH-1:0] out_mem_addr,
    output logic [DATA_WIDTH-1:0] out_mem_data,
    output logic                  out_mem_wr_en,
    input  logic [DATA_WIDTH-1:0] in_mem_data
);

    state_t                state;
    logic                  lat_we;
    logic                  lat_uns;
    logic [1:0]            lat_size;
    logic [DATA_WIDTH-1:0] lat_wdata;

    logic                  accept;
    logic                  acc_mis;
    logic                  acc_sd;
    logic [DATA_WIDTH-1:0] ext_data;
    logic [DATA_WIDTH-1:0] byte_mask;
    logic [DATA_WIDTH-1:0] merged;

    assign out_ready = (state == ST_IDLE);
    assign accept    = in_req && out_ready;
    assign acc_mis   = misalign(in_addr[2:0], in_size);
    // A full doubleword store overwrites all 8 bytes, so it needs no read first.
    assign acc_sd    = in_we && (in_size == SIZE_D);

    lsu_extend u_extend (
        .size        (lat_size),
        .is_unsigned (lat_uns),
        .raw         (in_mem_data),
        .ext         (ext_data),
        .byte_mask   (byte_mask)
    );

    // The memory always writes 8 bytes, so a narrow store keeps the bytes it just read
    // and replaces only the accessed field with the low bytes of the store data.
    assign merged = (in_mem_data & ~byte_mask) | (lat_wdata & byte_mask);

    // Control FSM; valid, err and wr_en are registered so each is a clean one-cycle pulse.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state         <= ST_IDLE;
            out_valid     <= 1'b0;
            out_err       <= 1'b0;
            out_mem_wr_en <= 1'b0;
        end else begin
            out_valid     <= 1'b0;
            out_err       <= 1'b0;
            out_mem_wr_en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (acc_mis) begin
                            state     <= ST_RESP;
                            out_valid <= 1'b1;
                            out_err   <= 1'b1;
                        end else if (acc_sd) begin
                            state         <= ST_WR;
                            out_mem_wr_en <= 1'b1;
                        end else begin
                            state <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    if (lat_we) begin
                        state         <= ST_WR;
                        out_mem_wr_en <= 1'b1;
                    end else begin
                        state     <= ST_RESP;
                        out_valid <= 1'b1;
                    end
                end
                ST_WR: begin
                    state     <= ST_RESP;
                    out_valid <= 1'b1;
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Datapath: request latches, memory address/data and load result.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            lat_we       <= 1'b0;
            lat_uns      <= 1'b0;
            lat_size     <= SIZE_B;
            lat_wdata    <= '0;
            out_mem_addr <= '0;
            out_mem_data <= '0;
            out_rdata    <= '0;
        end else begin
            if (accept) begin
                lat_we       <= in_we;
                lat_uns      <= in_unsigned;
                lat_size     <= in_size;
                lat_wdata    <= in_wdata;
                out_mem_addr <= in_addr;
                // Stores and errors report zero; a load overwrites this in RD.
                out_rdata    <= '0;
                if (acc_sd && !acc_mis) begin
                    out_mem_data <= in_wdata;
                end
            end
            if (state == ST_RD) begin
                if (lat_we) begin
                    out_mem_data <= merged;
                end else begin
                    out_rdata <= ext_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Random and directed load/store traffic against a byte-array reference model.
// Latency: n/a (testbench).
// Backpressure: requests are driven only after out_ready is observed, except in the held-request run.
module tb_mem_access_unit;

    localparam int MEM_BYTES = 4104;

    logic        clk;
    logic        rst;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        ready;
    logic        valid;
    logic        err;
    logic [63:0] rdata;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_wr_en;
    logic [63:0] mem_rdata;

    logic [7:0] mem     [MEM_BYTES];
    logic [7:0] ref_mem [MEM_BYTES];

    int n_checks = 0;
    int n_errors = 0;

    mem_access_unit #(.DATA_WIDTH(64), .ADDR_WIDTH(64)) dut (
        .in_clk        (clk),
        .in_rst        (rst),
        .in_req        (req),
        .in_we         (we),
        .in_size       (size),
        .in_unsigned   (uns),
        .in_addr       (addr),
        .in_wdata      (wdata),
        .out_ready     (ready),
        .out_valid     (valid),
        .out_err       (err),
        .out_rdata     (rdata),
        .out_mem_addr  (mem_addr),
        .out_mem_data  (mem_wdata),
        .out_mem_wr_en (mem_wr_en),
        .in_mem_data   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: combinational 8-byte little-endian read, 8-byte write on the strobe.
    always_comb begin
        mem_rdata = '0;
        for (int i = 0; i < 8; i++) begin
            mem_rdata[8*i +: 8] = mem[int'(mem_addr[11:0]) + i];
        end
    end

    always @(posedge clk) begin
        if (mem_wr_en) begin
            for (int i = 0; i < 8; i++) begin
                mem[int'(mem_addr[11:0]) + i] <= mem_wdata[8*i +: 8];
            end
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    // Reference: a load reads n bytes starting at addr, then extends from bit 8n-1.
    function automatic logic [63:0] ref_load(input logic [63:0] a, input logic [1:0] sz, input logic u);
        int          n;
        logic [63:0] v;
        n = 1 << sz;
        v = '0;
        for (int i = 0; i < n; i++) begin
            v = v | (64'(ref_mem[int'(a[11:0]) + i]) << (8 * i));
        end
        if (n < 8 && !u && v[8*n-1]) begin
            v = v | (64'hFFFF_FFFF_FFFF_FFFF << (8 * n));
        end
        return v;
    endfunction

    task automatic ref_store(input logic [63:0] a, input logic [1:0] sz, input logic [63:0] d);
        for (int i = 0; i < (1 << sz); i++) begin
            ref_mem[int'(a[11:0]) + i] = d[8*i +: 8];
        end
    endtask

    logic [63:0] last_rdata;

    // One handshake; checks latency, err, data, strobe width and the return to idle.
    task automatic do_op(input logic w, input logic [1:0] sz, input logic u,
                         input logic [63:0] a, input logic [63:0] d);
        int          nbytes;
        logic        mis;
        int          exp_lat;
        int          exp_wr;
        logic [63:0] exp_rd;
        int          lat;
        int          wr_cycles;
        logic        got_valid;
        logic        got_err;
        logic        seen_ready;

        nbytes  = 1 << sz;
        mis     = (a % nbytes) != 0;
        exp_lat = mis ? 1 : (!w ? 2 : (sz == 2'd3 ? 2 : 3));
        exp_wr  = (mis || !w) ? 0 : 1;
        exp_rd  = (mis || w) ? 64'd0 : ref_load(a, sz, u);
        if (w && !mis) ref_store(a, sz, d);

        seen_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ready) begin
                seen_ready = 1'b1;
                break;
            end
        end
        if (!seen_ready) begin
            check_eq("ready_timeout", 64'(ready), 64'd1);
            return;
        end

        req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = d;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        addr = $urandom;

        lat = 0; wr_cycles = 0; got_valid = 1'b0; got_err = 1'b0; last_rdata = '0;
        for (int k = 1; k <= 20; k++) begin
            wr_cycles += int'(mem_wr_en);
            if (valid) begin
                lat = k; got_valid = 1'b1; got_err = err; last_rdata = rdata;
                break;
            end
            @(negedge clk);
        end
        check_eq("valid_seen", 64'(got_valid), 64'd1);
        check_eq("latency", 64'(lat), 64'(exp_lat));
        check_eq("err", 64'(got_err), 64'(mis));
        check_eq("rdata", last_rdata, exp_rd);
        check_eq("wr_en_cycles", 64'(wr_cycles), 64'(exp_wr));
        @(negedge clk);
        check_eq("valid_pulse", 64'(valid), 64'd0);
        check_eq("ready_after", 64'(ready), 64'd1);
    endtask

    task automatic check_mem(input string tag);
        int diffs;
        diffs = 0;
        for (int i = 0; i < MEM_BYTES; i++) begin
            if (mem[i] !== ref_mem[i]) diffs++;
        end
        check_eq(tag, 64'(diffs), 64'd0);
    endtask

    logic [63:0] held_addr [10];

    initial begin
        logic [1:0]  rsz;
        logic [63:0] ra;
        logic [63:0] exp_q [$];
        logic [63:0] got_q [$];

        for (int i = 0; i < MEM_BYTES; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        mem[16] = 8'h80; ref_mem[16] = 8'h80;
        for (int i = 0; i < 8; i++) begin
            mem[256 + i]     = 8'(8'h88 - 8'(i * 8'h11));
            ref_mem[256 + i] = mem[256 + i];
        end

        rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'd0; uns = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        check_eq("rst_ready", 64'(ready), 64'd1);
        check_eq("rst_valid", 64'(valid), 64'd0);
        check_eq("rst_err", 64'(err), 64'd0);
        check_eq("rst_wr_en", 64'(mem_wr_en), 64'd0);
        check_eq("rst_rdata", rdata, 64'd0);
        check_eq("rst_mem_addr", mem_addr, 64'd0);
        check_eq("rst_mem_data", mem_wdata, 64'd0);

        // Byte loads, signed and unsigned.
        do_op(1'b0, 2'd0, 1'b0, 64'h10, 64'd0);
        check_eq("lb_80", last_rdata, 64'hFFFF_FFFF_FFFF_FF80);
        do_op(1'b0, 2'd0, 1'b1, 64'h10, 64'd0);
        check_eq("lbu_80", last_rdata, 64'h0000_0000_0000_0080);

        // Narrow store merges into the existing doubleword.
        do_op(1'b1, 2'd0, 1'b0, 64'h100, 64'h0000_0000_0000_00AB);
        do_op(1'b0, 2'd3, 1'b0, 64'h100, 64'd0);
        check_eq("sb_merge", last_rdata, 64'h1122_3344_5566_77AB);

        // Doubleword store, read back whole and as an upper word.
        do_op(1'b1, 2'd3, 1'b0, 64'h200, 64'hDEAD_BEEF_CAFE_F00D);
        do_op(1'b0, 2'd3, 1'b0, 64'h200, 64'd0);
        check_eq("ld_200", last_rdata, 64'hDEAD_BEEF_CAFE_F00D);
        do_op(1'b0, 2'd2, 1'b0, 64'h204, 64'd0);
        check_eq("lw_204", last_rdata, 64'hFFFF_FFFF_DEAD_BEEF);

        // Misaligned halfword store must not touch memory.
        do_op(1'b1, 2'd1, 1'b0, 64'h21, 64'h0000_0000_0000_BEEF);
        check_mem("mem_after_misalign");

        // Randomized traffic, mostly aligned.
        for (int t = 0; t < 80; t++) begin
            rsz = 2'($urandom_range(0, 3));
            ra  = 64'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) != 0) ra = ra & ~((64'd1 << rsz) - 64'd1);
            do_op(1'($urandom), rsz, 1'($urandom), ra, {$urandom, $urandom});
        end
        check_mem("mem_after_random");

        // Request held high for 10 cycles with a new address every cycle: a load
        // occupies IDLE->RD->RESP, so only every third cycle's request is taken.
        for (int i = 0; i < 10; i++) held_addr[i] = 64'($urandom_range(0, 127)) << 3;
        for (int i = 0; i < 10; i += 3) exp_q.push_back(ref_load(held_addr[i], 2'd3, 1'b0));
        for (int i = 0; i < 16; i++) begin
            if (valid) got_q.push_back(rdata);
            if (i < 10) begin
                req = 1'b1; we = 1'b0; size = 2'd3; uns = 1'b0; addr = held_addr[i];
            end else begin
                req = 1'b0;
            end
            @(negedge clk);
        end
        check_eq("held_count", 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check_eq("held_rdata", got_q[i], exp_q[i]);
        end

        // Reset during the WR cycle of a doubleword store.
        req = 1'b1; we = 1'b1; size = 2'd3; uns = 1'b0; addr = 64'h300; wdata = 64'h0123_4567_89AB_CDEF;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        check_eq("wr_cycle_wr_en", 64'(mem_wr_en), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_eq("rst_wr_ready", 64'(ready), 64'd1);
        check_eq("rst_wr_wr_en", 64'(mem_wr_en), 64'd0);
        check_eq("rst_wr_valid", 64'(valid), 64'd0);
        // The strobe was high on the reset edge, so this memory model took the write.
        ref_store(64'h300, 2'd3, 64'h0123_4567_89AB_CDEF);
        @(negedge clk);
        check_eq("rst_wr_no_resp", 64'(valid), 64'd0);
        do_op(1'b0, 2'd3, 1'b0, 64'h300, 64'd0);
        check_mem("mem_final");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
